// File: rtl/lcd_bus_decoder.sv
// Receive side of a 4-bit HD44780-style LCD bus: reassembles nibbles into bytes and shadows the DDRAM cursor.
// Latency SYNC_STAGES+2 clk from an E falling edge to a pulse; passive monitor with no backpressure.
module lcd_bus_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_W,
    input  logic [3:0] data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic [6:0] byte_addr,
    output logic       mode_4bit,
    output logic [6:0] ddram_addr,
    output logic       proto_err,
    output logic       read_seen
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, HAVE_HI} state_t;

    // bus word layout: {E, RS, W, data[3:0]}
    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] synced;
    logic       e_prev;
    logic       stb_q, stb_rs, stb_w;
    logic [3:0] stb_dat;

    state_t     state, state_n;
    logic [3:0] hi_q, hi_n;
    logic       hi_rs_q, hi_rs_n;
    logic [CW-1:0] cnt_q, cnt_n;

    logic       bv_n, brs_n, mode_n, perr_n, rd_n;
    logic [7:0] bd_n;
    logic [6:0] ba_n, addr_n;
    logic       emit, emit_rs;
    logic [7:0] emit_byte;

    assign synced = sync_q[SYNC_STAGES-1];

    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_prev  <= 1'b0;
            stb_q   <= 1'b0;
            stb_rs  <= 1'b0;
            stb_w   <= 1'b0;
            stb_dat <= 4'h0;
        end else begin
            sync_q[0] <= {LCD_E, LCD_RS, LCD_W, data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_prev  <= synced[6];
            stb_q   <= e_prev & ~synced[6];
            stb_rs  <= synced[5];
            stb_w   <= synced[4];
            stb_dat <= synced[3:0];
        end
    end

    always_comb begin
        state_n   = state;
        hi_n      = hi_q;
        hi_rs_n   = hi_rs_q;
        cnt_n     = cnt_q;
        mode_n    = mode_4bit;
        addr_n    = ddram_addr;
        bv_n      = 1'b0;
        bd_n      = byte_data;
        brs_n     = byte_rs;
        ba_n      = byte_addr;
        perr_n    = 1'b0;
        rd_n      = 1'b0;
        emit      = 1'b0;
        emit_byte = 8'h00;
        emit_rs   = 1'b0;

        if (stb_q && stb_w) begin
            rd_n = 1'b1;
        end else if (stb_q && !mode_4bit) begin
            emit      = 1'b1;
            emit_byte = {stb_dat, 4'h0};
            emit_rs   = stb_rs;
            if (stb_dat == 4'h2 && !stb_rs) mode_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (stb_q) begin
                        hi_n    = stb_dat;
                        hi_rs_n = stb_rs;
                        cnt_n   = '0;
                        state_n = HAVE_HI;
                    end
                end
                HAVE_HI: begin
                    if (stb_q) begin
                        state_n = IDLE;
                        hi_n    = 4'h0;
                        if (stb_rs == hi_rs_q) begin
                            emit      = 1'b1;
                            emit_byte = {hi_q, stb_dat};
                            emit_rs   = stb_rs;
                        end else begin
                            perr_n = 1'b1;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        perr_n  = 1'b1;
                        hi_n    = 4'h0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (emit) begin
            bv_n  = 1'b1;
            bd_n  = emit_byte;
            brs_n = emit_rs;
            if (emit_rs) begin
                ba_n   = ddram_addr;
                addr_n = addr_inc(ddram_addr);
            end else if (emit_byte == 8'h01 || emit_byte[7:1] == 7'b0000001) begin
                addr_n = 7'h00;
            end else if (emit_byte[7]) begin
                addr_n = emit_byte[6:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hi_q       <= 4'h0;
            hi_rs_q    <= 1'b0;
            cnt_q      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
            byte_addr  <= 7'h00;
            mode_4bit  <= 1'b0;
            ddram_addr <= 7'h00;
            proto_err  <= 1'b0;
            read_seen  <= 1'b0;
        end else begin
            state      <= state_n;
            hi_q       <= hi_n;
            hi_rs_q    <= hi_rs_n;
            cnt_q      <= cnt_n;
            byte_valid <= bv_n;
            byte_data  <= bd_n;
            byte_rs    <= brs_n;
            byte_addr  <= ba_n;
            mode_4bit  <= mode_n;
            ddram_addr <= addr_n;
            proto_err  <= perr_n;
            read_seen  <= rd_n;
        end
    end

endmodule
